// File: rtl/shift_deserializer.sv
// shift_deserializer
//   Serial-to-parallel receiver. It samples one bit on each i_shift strobe, MSB first, and
//   assembles WIDTH-bit words. Each word is offered on a valid/ready port, and the block
//   reports framing and overrun errors through sticky flags.
//
// Parameters
//   WIDTH   word width in bits (>= 2)
//   FRAMED  1: word alignment comes from i_frame; 0: free-running from reset
//
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_sdata     serial data bit
//   i_shift     bit strobe; i_sdata is sampled when high
//   i_frame     first-bit marker, qualified by i_shift
//   i_ready     consumer accepts o_data when this and o_valid are both high
//   i_clr_err   clears the sticky error flags
//   o_data      assembled word; the MSB is the first bit received
//   o_valid     o_data holds an unaccepted word
//   o_overrun   sticky: a completed word was dropped
//   o_sync_err  sticky: i_frame arrived mid-word
//   o_busy      a partial word is in progress
module shift_deserializer #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          FRAMED = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sdata,
  input  logic             i_shift,
  input  logic             i_frame,
  input  logic             i_ready,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_sync_err,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;
  logic             busy_q, busy_d;

  logic word_done;
  logic sync_set;
  logic ovr_set;
  logic xfer;

  // Bit assembly and word alignment
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    sync_set  = 1'b0;
    if (i_shift) begin
      if (FRAMED && (state_q == StHunt)) begin
        if (i_frame) begin
          sr_d    = {{(WIDTH-1){1'b0}}, i_sdata};
          cnt_d   = CntW'(1);
          state_d = StRecv;
        end
      end else if (FRAMED && i_frame && (cnt_q != '0)) begin
        // Frame marker mid-word: drop the partial word and restart on this bit
        sync_set = 1'b1;
        sr_d     = {{(WIDTH-1){1'b0}}, i_sdata};
        cnt_d    = CntW'(1);
      end else begin
        sr_d = {sr_q[WIDTH-2:0], i_sdata};
        if (cnt_q == CntW'(WIDTH-1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Holding register, handshake and sticky errors
  always_comb begin
    xfer    = valid_q & i_ready;
    valid_d = valid_q & ~xfer;
    data_d  = data_q;
    ovr_set = 1'b0;
    if (word_done) begin
      if (!valid_q || i_ready) begin
        data_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        // The held word stays in place; the new one is lost
        ovr_set = 1'b1;
      end
    end
    // A new error event takes priority over a clear in the same cycle
    overrun_d  = ovr_set | (overrun_q & ~i_clr_err);
    sync_err_d = sync_set | (sync_err_q & ~i_clr_err);
    busy_d     = (cnt_d != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FRAMED ? StHunt : StRecv;
      sr_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_overrun  = overrun_q;
  assign o_sync_err = sync_err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: one framed instance and one free-running instance.
// Inputs change on the falling edge, and outputs are checked on the following falling edge.
module tb_shift_deserializer;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic sdata = 1'b0;
  logic shift = 1'b0;
  logic frame = 1'b0;
  logic ready = 1'b0;
  logic clr_err = 1'b0;

  logic [7:0] data0, data1;
  logic       valid0, overrun0, sync0, busy0;
  logic       valid1, overrun1, sync1, busy1;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  logic [7:0] last_xfer = 8'h00;
  int base;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(8), .FRAMED(1'b1)) u_framed (
    .i_clk(clk), .i_rst(rst0), .i_sdata(sdata), .i_shift(shift), .i_frame(frame),
    .i_ready(ready), .i_clr_err(clr_err), .o_data(data0), .o_valid(valid0),
    .o_overrun(overrun0), .o_sync_err(sync0), .o_busy(busy0)
  );

  shift_deserializer #(.WIDTH(8), .FRAMED(1'b0)) u_free (
    .i_clk(clk), .i_rst(rst1), .i_sdata(sdata), .i_shift(shift), .i_frame(frame),
    .i_ready(ready), .i_clr_err(clr_err), .o_data(data1), .o_valid(valid1),
    .o_overrun(overrun1), .o_sync_err(sync1), .o_busy(busy1)
  );

  // Record every accepted word on the framed instance
  always @(posedge clk) begin
    if (valid0 && ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= data0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return on the falling edge after they were sampled
  task automatic step(input logic s, input logic d, input logic f);
    shift = s;
    sdata = d;
    frame = f;
    @(negedge clk);
    shift = 1'b0;
    frame = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic framed);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], framed && (i == 7));
  endtask

  initial begin
    logic [7:0] w;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("rst_data", data0, 8'h00);
    check_eq("rst_valid", valid0, 1'b0);
    check_eq("rst_overrun", overrun0, 1'b0);
    check_eq("rst_sync", sync0, 1'b0);
    check_eq("rst_busy", busy0, 1'b0);
    rst0 = 1'b0;

    // Hunt: strobes without a frame marker are ignored
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], 1'b0);
      check_eq("hunt_busy", busy0, 1'b0);
      check_eq("hunt_valid", valid0, 1'b0);
    end

    // Single word 0xA5
    ready = 1'b1;
    w = 8'hA5;
    step(1'b1, w[7], 1'b1);
    check_eq("single_busy_first", busy0, 1'b1);
    for (int i = 6; i >= 1; i--) step(1'b1, w[i], 1'b0);
    check_eq("single_valid_early", valid0, 1'b0);
    step(1'b1, w[0], 1'b0);
    check_eq("single_valid", valid0, 1'b1);
    check_eq("single_data", data0, 8'hA5);
    check_eq("single_busy_done", busy0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("single_pulse_end", valid0, 1'b0);
    check_eq("single_overrun", overrun0, 1'b0);
    check_eq("single_sync", sync0, 1'b0);
    check_eq("single_xfer", last_xfer, 8'hA5);

    // Back-to-back with hold
    ready = 1'b0;
    base = xfer_cnt;
    send_word(8'h3C, 1'b1);
    check_eq("b2b_valid", valid0, 1'b1);
    check_eq("b2b_data1", data0, 8'h3C);
    check_eq("b2b_no_ovr_yet", overrun0, 1'b0);
    send_word(8'hC3, 1'b1);
    check_eq("b2b_overrun", overrun0, 1'b1);
    check_eq("b2b_data_held", data0, 8'h3C);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("b2b_data_hold20", data0, 8'h3C);
    check_eq("b2b_valid_hold20", valid0, 1'b1);
    ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_eq("b2b_valid_after", valid0, 1'b0);
    check_eq("b2b_xfer_cnt", xfer_cnt - base, 1);
    check_eq("b2b_xfer_data", last_xfer, 8'h3C);
    clr_err = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    check_eq("clr_overrun", overrun0, 1'b0);

    // Concurrent accept: ready rises in the cycle 0x81 completes
    ready = 1'b0;
    send_word(8'h7E, 1'b1);
    check_eq("conc_hold_data", data0, 8'h7E);
    w = 8'h81;
    for (int i = 7; i >= 1; i--) step(1'b1, w[i], i == 7);
    ready = 1'b1;
    step(1'b1, w[0], 1'b0);
    check_eq("conc_valid", valid0, 1'b1);
    check_eq("conc_data", data0, 8'h81);
    check_eq("conc_overrun", overrun0, 1'b0);
    check_eq("conc_prev_xfer", last_xfer, 8'h7E);
    step(1'b0, 1'b0, 1'b0);
    check_eq("conc_valid_end", valid0, 1'b0);
    check_eq("conc_xfer_data", last_xfer, 8'h81);

    // Resync after 3 bits
    base = xfer_cnt;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("resync_busy", busy0, 1'b1);
    send_word(8'h5A, 1'b1);
    check_eq("resync_sync", sync0, 1'b1);
    check_eq("resync_valid", valid0, 1'b1);
    check_eq("resync_data", data0, 8'h5A);
    check_eq("resync_no_partial", xfer_cnt - base, 0);
    clr_err = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    check_eq("resync_clr", sync0, 1'b0);
    check_eq("resync_xfer_cnt", xfer_cnt - base, 1);
    check_eq("resync_xfer_data", last_xfer, 8'h5A);

    // Set beats clear in the same cycle
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    clr_err = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    clr_err = 1'b0;
    check_eq("set_wins", sync0, 1'b1);
    clr_err = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    check_eq("set_wins_clr", sync0, 1'b0);

    // Reset mid-word discards the held word and the partial word
    ready = 1'b0;
    send_word(8'h11, 1'b1);
    check_eq("pre_rst_valid", valid0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst0 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst0 = 1'b0;
    check_eq("mrst_data", data0, 8'h00);
    check_eq("mrst_valid", valid0, 1'b0);
    check_eq("mrst_overrun", overrun0, 1'b0);
    check_eq("mrst_sync", sync0, 1'b0);
    check_eq("mrst_busy", busy0, 1'b0);
    ready = 1'b1;
    send_word(8'h01, 1'b1);
    check_eq("post_rst_valid", valid0, 1'b1);
    check_eq("post_rst_data", data0, 8'h01);
    check_eq("post_rst_overrun", overrun0, 1'b0);
    check_eq("post_rst_sync", sync0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Free-running instance: frame toggles randomly and must be ignored
    rst1 = 1'b0;
    check_eq("free_rst_busy", busy1, 1'b0);
    w = 8'h12;
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'($urandom_range(0, 1)));
    check_eq("free_valid1", valid1, 1'b1);
    check_eq("free_data1", data1, 8'h12);
    w = 8'h34;
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'($urandom_range(0, 1)));
    check_eq("free_valid2", valid1, 1'b1);
    check_eq("free_data2", data1, 8'h34);
    check_eq("free_sync", sync1, 1'b0);
    check_eq("free_overrun", overrun1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("free_valid_end", valid1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
